sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/fifo_ram.sv | 29 ++
 rtl/sync_fifo.sv | 111 +++++++++++
 tb/tb_sync_fifo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_ram.sv
// fifo_ram: WIDTH x DEPTH storage with one write port and one registered read port.
// The array has no reset; contents are only meaningful once written.
module fifo_ram #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDRESS_SIZE = 4
) (
  input  logic                    clock,
  input  logic                    wr_en,
  input  logic [ADDRESS_SIZE-1:0] wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  input  logic [ADDRESS_SIZE-1:0] rd_addr,
  output logic [WIDTH-1:0]        rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Synchronous read; a same-address write on the same edge returns the old word
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered status flags and one-cycle
// overflow/underflow pulses. Define SYNC_FIFO_ALMOST_FLAGS_EN to get threshold
// almost_full/almost_empty; otherwise they mirror full/empty.
module sync_fifo #(
  parameter int unsigned WIDTH              = 32,
  parameter int unsigned DEPTH              = 16,
  parameter int unsigned ADDRESS_SIZE       = 4,
  parameter int unsigned ALMOST_FULL_LEVEL  = 12,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    pop,
  output logic [WIDTH-1:0]        data_out,
  output logic                    full,
  output logic                    empty,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    almost_full,
  output logic                    almost_empty
);

  localparam int unsigned CW = ADDRESS_SIZE + 1;

  // Elaboration-time parameter legality
  if (DEPTH != (1 << ADDRESS_SIZE) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be 2**ADDRESS_SIZE and >= 2");
  end
  if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH - 1 ||
      ALMOST_EMPTY_LEVEL < 1 || ALMOST_EMPTY_LEVEL > DEPTH - 1) begin : g_bad_level
    $error("sync_fifo: almost levels must lie in 1..DEPTH-1");
  end

  logic [ADDRESS_SIZE-1:0] wr_ptr;
  logic [ADDRESS_SIZE-1:0] rd_ptr;
  logic                    rd_valid;
  logic [WIDTH-1:0]        ram_q;
  logic                    push_ok_c;
  logic                    pop_ok_c;
  logic [CW-1:0]           count_nxt_c;

  // Accept rules: a full FIFO still takes a push when a pop frees a slot
  always_comb begin
    push_ok_c   = 1'b0;
    pop_ok_c    = 1'b0;
    count_nxt_c = count;
    pop_ok_c    = pop && !empty;
    push_ok_c   = push && (!full || pop);
    count_nxt_c = count + CW'(push_ok_c) - CW'(pop_ok_c);
  end

  // Pointers, occupancy, status flags and error pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + ADDRESS_SIZE'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + ADDRESS_SIZE'(1);
      count     <= count_nxt_c;
      full      <= (count_nxt_c == CW'(DEPTH));
      empty     <= (count_nxt_c == '0);
      overflow  <= push && full && !pop;
      underflow <= pop && empty;
      rd_valid  <= rd_valid || pop_ok_c;
    end
  end

`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  // Threshold flags registered from the next occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_nxt_c >= CW'(ALMOST_FULL_LEVEL));
      almost_empty <= (count_nxt_c <= CW'(ALMOST_EMPTY_LEVEL));
    end
  end
`else
  assign almost_full  = full;
  assign almost_empty = empty;
`endif

  // Read data holds the last popped word; reads as zero until the first pop after reset
  assign data_out = rd_valid ? ram_q : '0;

  fifo_ram #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .ADDRESS_SIZE (ADDRESS_SIZE)
  ) u_ram (
    .clock   (clock),
    .wr_en   (push_ok_c),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (pop_ok_c),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed checks of sync_fifo (WIDTH=32, DEPTH=16).
module tb_sync_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AS    = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             push;
  logic [WIDTH-1:0] data_in;
  logic             pop;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [AS:0]      count;
  logic             overflow;
  logic             underflow;
  logic             almost_full;
  logic             almost_empty;

  int vectors    = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_v;

  sync_fifo #(
    .WIDTH              (WIDTH),
    .DEPTH              (DEPTH),
    .ADDRESS_SIZE       (AS),
    .ALMOST_FULL_LEVEL  (12),
    .ALMOST_EMPTY_LEVEL (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the rising edge
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
    push    = p;
    pop     = q;
    data_in = d;
    @(posedge clock);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  function automatic logic exp_af(input int c);
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    return logic'(c >= 12);
`else
    return logic'(c == 16);
`endif
  endfunction

  function automatic logic exp_ae(input int c);
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    return logic'(c <= 4);
`else
    return logic'(c == 0);
`endif
  endfunction

  initial begin
    reset_n = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    data_in = '0;
    #12;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    check("rst_almost_empty", 64'(almost_empty), 64'd1);
    check("rst_almost_full", 64'(almost_full), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Fill with 0x1..0x10
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, WIDTH'(i));
      check($sformatf("fill_count_%0d", i), 64'(count), 64'(i));
      check($sformatf("fill_full_%0d", i), 64'(full), 64'(i == 16));
      check($sformatf("fill_af_%0d", i), 64'(almost_full), 64'(exp_af(i)));
      check($sformatf("fill_ae_%0d", i), 64'(almost_empty), 64'(exp_ae(i)));
    end

    // Push while full without pop: rejected
    step(1'b1, 1'b0, 32'h11);
    check("ovf_pulse", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd16);
    step(1'b0, 1'b0, '0);
    check("ovf_clear", 64'(overflow), 64'd0);

    // Full with push+pop: both accepted
    step(1'b1, 1'b1, 32'hAA);
    check("fullpp_data", 64'(data_out), 64'h1);
    check("fullpp_count", 64'(count), 64'd16);
    check("fullpp_ovf", 64'(overflow), 64'd0);

    // Drain: 0x2..0x10 then 0xAA on the 16th pop after the push
    for (int i = 2; i <= 16; i++) begin
      step(1'b0, 1'b1, '0);
      check($sformatf("drain_data_%0d", i), 64'(data_out), 64'(i));
    end
    step(1'b0, 1'b1, '0);
    check("drain_aa", 64'(data_out), 64'hAA);
    check("drain_count", 64'(count), 64'd0);
    check("drain_empty", 64'(empty), 64'd1);

    // Pop when empty: rejected, data_out holds
    step(1'b0, 1'b1, '0);
    check("unf_pulse", 64'(underflow), 64'd1);
    check("unf_data", 64'(data_out), 64'hAA);
    check("unf_count", 64'(count), 64'd0);
    step(1'b0, 1'b0, '0);
    check("unf_clear", 64'(underflow), 64'd0);

    // Empty with push+pop: only the push is taken, no bypass
    step(1'b1, 1'b1, 32'h55);
    check("emptypp_unf", 64'(underflow), 64'd1);
    check("emptypp_count", 64'(count), 64'd1);
    check("emptypp_data", 64'(data_out), 64'hAA);
    step(1'b0, 1'b1, '0);
    check("emptypp_pop", 64'(data_out), 64'h55);

    // 40 interleaved values across several pointer wraps
    model_q.push_back(32'h100);
    step(1'b1, 1'b0, 32'h100);
    for (int k = 1; k < 40; k++) begin
      model_q.push_back(WIDTH'(32'h100 + k));
      step(1'b1, 1'b1, WIDTH'(32'h100 + k));
      exp_v = model_q.pop_front();
      check($sformatf("ilv_%0d", k), 64'(data_out), 64'(exp_v));
    end
    step(1'b0, 1'b1, '0);
    exp_v = model_q.pop_front();
    check("ilv_last", 64'(data_out), 64'(exp_v));
    check("ilv_count", 64'(count), 64'd0);

    // Asynchronous reset mid-operation with count=7
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, WIDTH'(32'h200 + i));
    check("pre_rst_count", 64'(count), 64'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_count", 64'(count), 64'd0);
    check("arst_data", 64'(data_out), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 32'h77);
    step(1'b0, 1'b1, '0);
    check("post_rst_data", 64'(data_out), 64'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
